// File: rtl/cpu_io_responder.sv
// CPU bus responder: 16-byte I/O window holding a UART transmitter with TX FIFO, tick timer and baud divisor.
// Optional interrupt flag and O_IRQ port are built when CPU_IO_RESPONDER_IRQ_EN is defined.
module cpu_io_responder #(
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_DIV   = 16'd216,
  parameter int          TICK_DIV   = 25000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_DATA,
  input  logic        I_WREN,
  output logic [7:0]  O_DATA,
  input  logic [7:0]  RAM_Q,
  output logic        RAM_WREN,
  output logic        UART_TX
`ifdef CPU_IO_RESPONDER_IRQ_EN
  ,
  output logic        O_IRQ
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic            in_window;
  logic [3:0]      offset;
  logic            wr_io;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, push, pop;
  logic            ovf, irqf;
  logic [PRE_W-1:0] presc;
  logic [15:0]     timer;
  logic [7:0]      shadow;
  logic            timer_clr, tick;
  logic [15:0]     div_reg, div_active, baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            baud_done;
  tx_state_t       state, state_d;
  logic            tx_line;
  logic [7:0]      reg_rdata;

  assign in_window = (I_ADDR[15:4] == IO_BASE[15:4]);
  assign offset    = I_ADDR[3:0];
  assign wr_io     = I_WREN & in_window;
  assign RAM_WREN  = I_WREN & ~in_window;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push       = wr_io && (offset == 4'd0) && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;

  // FIFO storage carries data only, so it is left out of reset
  always_ff @(posedge CLOCK) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= I_DATA;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_io && (offset == 4'd0) && fifo_full) ovf <= 1'b1;
      else if (wr_io && (offset == 4'd1))         ovf <= 1'b0;
    end
  end

  assign timer_clr = wr_io && (offset == 4'd2);
  assign tick      = (presc == PRE_MAX);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      presc  <= '0;
      timer  <= '0;
      shadow <= '0;
    end else begin
      if (timer_clr) begin
        presc <= '0;
        timer <= '0;
      end else if (tick) begin
        presc <= '0;
        timer <= timer + 16'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      // High byte is captured while the low byte is read so a 16-bit read is coherent
      if (in_window && (offset == 4'd2) && !I_WREN) shadow <= timer[15:8];
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      div_reg <= BAUD_DIV;
    end else begin
      if (wr_io && (offset == 4'd4)) div_reg[7:0]  <= I_DATA;
      if (wr_io && (offset == 4'd5)) div_reg[15:8] <= I_DATA;
    end
  end

  assign baud_done = (baud_cnt == div_active);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    tx_line = 1'b1;
    case (state)
      IDLE:  if (!fifo_empty) state_d = START;
      START: begin
        tx_line = 1'b0;
        if (baud_done) state_d = DATA;
      end
      DATA: begin
        tx_line = shift_reg[0];
        if (baud_done && (bit_cnt == 3'd7)) state_d = STOP;
      end
      STOP:  if (baud_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign UART_TX = tx_line;

  // Divisor is sampled at the pop so a mid-frame divisor write cannot distort the frame
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      div_active <= BAUD_DIV;
    end else if (pop) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      div_active <= div_reg;
    end else if (state != IDLE) begin
      if (baud_done) begin
        baud_cnt <= '0;
        if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (pop)                             shift_reg <= fifo_mem[rd_ptr[AW-1:0]];
    else if (state == DATA && baud_done) shift_reg <= {1'b0, shift_reg[7:1]};
  end

`ifdef CPU_IO_RESPONDER_IRQ_EN
  logic timer_wrap, frame_done;
  assign timer_wrap = tick && !timer_clr && (timer == 16'hFFFF);
  assign frame_done = (state == STOP) && baud_done;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                                irqf <= 1'b0;
    else if (timer_wrap || (frame_done && fifo_empty)) irqf <= 1'b1;
    else if (wr_io && (offset == 4'd1))        irqf <= 1'b0;
  end

  assign O_IRQ = irqf;
`else
  assign irqf = 1'b0;
`endif

  always_comb begin
    reg_rdata = 8'hFF;
    case (offset)
      4'd0: reg_rdata = 8'h00;
      4'd1: reg_rdata = {3'b000, irqf, ovf, (state != IDLE), fifo_full, fifo_empty};
      4'd2: reg_rdata = timer[7:0];
      4'd3: reg_rdata = shadow;
      4'd4: reg_rdata = div_reg[7:0];
      4'd5: reg_rdata = div_reg[15:8];
      default: reg_rdata = 8'hFF;
    endcase
    O_DATA = in_window ? reg_rdata : RAM_Q;
  end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder; UART line levels are predicted per clock into a scoreboard queue.
module tb_cpu_io_responder;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [15:0] I_ADDR;
  logic [7:0]  I_DATA;
  logic        I_WREN;
  logic [7:0]  O_DATA;
  logic [7:0]  RAM_Q;
  logic        RAM_WREN;
  logic        UART_TX;
`ifdef CPU_IO_RESPONDER_IRQ_EN
  logic        O_IRQ;
  localparam logic [7:0] ST_MASK = 8'hEF;
`else
  localparam logic [7:0] ST_MASK = 8'hFF;
`endif

  int   vectors = 0;
  int   errors  = 0;
  logic exp_q[$];
  int   bit_clks = 4;

  cpu_io_responder #(.TICK_DIV(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_WREN(I_WREN),
    .O_DATA(O_DATA), .RAM_Q(RAM_Q), .RAM_WREN(RAM_WREN), .UART_TX(UART_TX)
`ifdef CPU_IO_RESPONDER_IRQ_EN
    , .O_IRQ(O_IRQ)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic [15:0] a, input logic [7:0] d, input logic we);
    I_ADDR = a;
    I_DATA = d;
    I_WREN = we;
    #1;
  endtask

  // Advance one clock and compare the serial line against the next predicted level
  task automatic cyc();
    @(posedge CLOCK);
    #1;
    if (exp_q.size() > 0) check("uart_tx", UART_TX, exp_q.pop_front());
    else                  check("uart_idle", UART_TX, 1'b1);
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b1);
    repeat (bit_clks) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (bit_clks) exp_q.push_back(b[i]);
    repeat (bit_clks) exp_q.push_back(1'b1);
  endtask

  task automatic write_reg(input logic [3:0] off, input logic [7:0] d);
    set_bus({12'hFF0, off}, d, 1'b1);
    cyc();
    I_WREN = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] d, input logic accepted);
    if (accepted) push_frame(d);
    write_reg(4'd0, d);
  endtask

  initial begin
    RESET  = 1'b1;
    RAM_Q  = 8'h5A;
    set_bus(16'h1234, 8'h00, 1'b0);
    #1;
    // Reset state and decode
    check("rst_ram_pass", O_DATA, 8'h5A);
    check("rst_uart", UART_TX, 1'b1);
    set_bus(16'hFF01, 8'h00, 1'b0); check("rst_status", O_DATA & ST_MASK, 8'h01);
    set_bus(16'hFF00, 8'h00, 1'b0); check("rd_uart_data", O_DATA, 8'h00);
    set_bus(16'hFF04, 8'h00, 1'b0); check("rst_div_lo", O_DATA, 8'hD8);
    set_bus(16'hFF05, 8'h00, 1'b0); check("rst_div_hi", O_DATA, 8'h00);
    set_bus(16'hFF02, 8'h00, 1'b0); check("rst_timer", O_DATA, 8'h00);
    set_bus(16'hFF07, 8'h00, 1'b0); check("rd_unmapped7", O_DATA, 8'hFF);
    set_bus(16'hFF0F, 8'h00, 1'b0); check("rd_unmapped15", O_DATA, 8'hFF);
    set_bus(16'h1234, 8'h00, 1'b1); check("ramwren_out", RAM_WREN, 1'b1);
    set_bus(16'hFF05, 8'h00, 1'b1); check("ramwren_in", RAM_WREN, 1'b0);
    set_bus(16'h0000, 8'h00, 1'b0);
`ifdef CPU_IO_RESPONDER_IRQ_EN
    check("rst_irq", O_IRQ, 1'b0);
`endif
    cyc();
    RESET = 1'b0;

    // Window edges pass RAM data through
    RAM_Q = 8'hC3;
    set_bus(16'hFEFF, 8'h00, 1'b0); check("below_window", O_DATA, 8'hC3);
    set_bus(16'hFF10, 8'h00, 1'b0); check("above_window", O_DATA, 8'hC3);
    set_bus(16'hFF10, 8'h00, 1'b1); check("ramwren_above", RAM_WREN, 1'b1);
    set_bus(16'h0000, 8'h00, 1'b0);

    // Single frame at divisor 3
    write_reg(4'd4, 8'h03);
    write_reg(4'd5, 8'h00);
    set_bus(16'hFF04, 8'h00, 1'b0); check("div_lo_rd", O_DATA, 8'h03);
    write_data(8'hA5, 1'b1);
    set_bus(16'hFF01, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc();
      check("status_busy", O_DATA & 8'hFE & ST_MASK, 8'h04);
    end
    cyc();
    check("status_done", O_DATA & ST_MASK, 8'h01);
`ifdef CPU_IO_RESPONDER_IRQ_EN
    check("irq_frame_end", O_IRQ, 1'b1);
    write_reg(4'd1, 8'h00);
    check("irq_cleared", O_IRQ, 1'b0);
`endif

    // Overflow: first byte pops at once, next eight fill, last is dropped
    for (int i = 0; i < 10; i++) write_data(8'(i), (i < 9));
    set_bus(16'hFF01, 8'h00, 1'b0); check("status_full_ovf", O_DATA & ST_MASK, 8'h0E);
    write_reg(4'd1, 8'h00);
    set_bus(16'hFF01, 8'h00, 1'b0); check("status_ovf_clr", O_DATA & ST_MASK, 8'h06);
    while (exp_q.size() > 0) cyc();
    cyc();
    check("status_drained", O_DATA & ST_MASK, 8'h01);
`ifdef CPU_IO_RESPONDER_IRQ_EN
    write_reg(4'd1, 8'h00);
`endif

    // Timer with TICK_DIV=4
    write_reg(4'd2, 8'h5A);
    set_bus(16'h0000, 8'h00, 1'b0);
    repeat (4 * 16'h0123) cyc();
    set_bus(16'hFF02, 8'h00, 1'b0); check("timer_lo", O_DATA, 8'h23);
    cyc();
    set_bus(16'hFF03, 8'h00, 1'b0); check("timer_hi", O_DATA, 8'h01);
    write_reg(4'd2, 8'h00);
    set_bus(16'hFF02, 8'h00, 1'b0); check("timer_clr_lo", O_DATA, 8'h00);
    repeat (3) cyc();
    check("presc_clr", O_DATA, 8'h00);
    cyc();
    check("timer_first_tick", O_DATA, 8'h01);
    set_bus(16'hFF03, 8'h00, 1'b0); check("timer_clr_hi", O_DATA, 8'h00);

    // Reset in the middle of a data bit
    write_data(8'h3C, 1'b1);
    set_bus(16'h0000, 8'h00, 1'b0);
    repeat (9) cyc();
    check("tx_mid_bit", UART_TX, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check("tx_async_rst", UART_TX, 1'b1);
    exp_q.delete();
    set_bus(16'hFF01, 8'h00, 1'b0); check("rst2_status", O_DATA & ST_MASK, 8'h01);
    set_bus(16'hFF04, 8'h00, 1'b0); check("rst2_div_lo", O_DATA, 8'hD8);
    set_bus(16'hFF05, 8'h00, 1'b0); check("rst2_div_hi", O_DATA, 8'h00);
`ifdef CPU_IO_RESPONDER_IRQ_EN
    check("rst2_irq", O_IRQ, 1'b0);
`endif
    cyc();
    RESET = 1'b0;
    set_bus(16'h0000, 8'h00, 1'b0);
    repeat (60) cyc();
    set_bus(16'hFF01, 8'h00, 1'b0); check("post_rst_status", O_DATA & ST_MASK, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
